// File: rtl/psramc_pkg.sv
// Shared constants for the PSRAM SPI controller: register offsets,
// CTRL/STATUS bit positions and the controller FSM state encoding.
package psramc_pkg;

   // Word indices (PADDR[4:2]) of the register map
   localparam logic [2:0] REG_CTRL    = 3'd0;
   localparam logic [2:0] REG_CYC_PU  = 3'd1;
   localparam logic [2:0] REG_CYC_CEM = 3'd2;
   localparam logic [2:0] REG_CLKDIV  = 3'd3;
   localparam logic [2:0] REG_TXDATA  = 3'd4;
   localparam logic [2:0] REG_RXDATA  = 3'd5;
   localparam logic [2:0] REG_STATUS  = 3'd6;

   // First byte address that is outside the register map
   localparam logic [7:0] ADDR_LIMIT = 8'h1C;

   // CTRL bit positions
   localparam int CTRL_EN   = 31;
   localparam int CTRL_HOLD = 8;
   localparam int CTRL_CPOL = 9;
   localparam int CTRL_CPHA = 10;

   // STATUS bit positions
   localparam int ST_BUSY    = 0;
   localparam int ST_PU_DONE = 1;
   localparam int ST_CEM_ERR = 2;
   localparam int ST_DONE    = 3;

   typedef enum logic [2:0] {
      S_OFF,
      S_PWRUP,
      S_IDLE,
      S_SHIFT,
      S_HOLD
   } state_t;

endpackage

// File: rtl/spi_shift_engine.sv
// SPI shift engine: SCLK divider, leading/trailing edge generation and the
// transmit/receive shift registers. A start pulse latches the data and the
// mode; finish is high in the last cycle of the final half-period.
module spi_shift_engine #(
   parameter int DW   = 8,
   parameter int DIVW = 8
) (
   input  logic            PCLK,
   input  logic            RESETN,
   input  logic            start,
   input  logic            abort,
   input  logic [DW-1:0]   tx_data,
   input  logic            cpol,
   input  logic            cpha,
   input  logic [DIVW-1:0] div,
   input  logic            miso,
   output logic            busy,
   output logic            finish,
   output logic            sclk,
   output logic            mosi,
   output logic [DW-1:0]   rx_data
);

   localparam int HW = $clog2(2 * DW);
   localparam logic [HW-1:0] LAST_HALF = HW'(2 * DW - 1);

   logic            active_reg;
   logic            cpha_reg;
   logic [DIVW-1:0] div_reg;
   logic [DIVW-1:0] cnt_reg;
   logic [HW-1:0]   half_reg;
   logic            sclk_reg;
   logic            mosi_reg;
   logic [DW-1:0]   tx_reg;
   logic [DW-1:0]   rx_reg;
   logic [DW-1:0]   rx_data_reg;

   logic          half_end;
   logic          lead_edge;
   logic          trail_edge;
   logic          last_edge;
   logic          shift_edge;
   logic          sample_edge;
   logic [DW-1:0] rx_shift;

   // Edge decode: even half-periods end on the leading edge, odd on the trailing
   always_comb begin
      half_end    = active_reg && (cnt_reg == div_reg);
      lead_edge   = half_end && !half_reg[0];
      trail_edge  = half_end && half_reg[0];
      last_edge   = half_end && (half_reg == LAST_HALF);
      shift_edge  = cpha_reg ? lead_edge : trail_edge;
      sample_edge = cpha_reg ? trail_edge : lead_edge;
      rx_shift    = {rx_reg[DW-2:0], miso};
   end

   // Divider, SCLK toggling and MSB-first shift/sample
   always_ff @(posedge PCLK) begin
      if (!RESETN) begin
         active_reg  <= 1'b0;
         cpha_reg    <= 1'b0;
         div_reg     <= '0;
         cnt_reg     <= '0;
         half_reg    <= '0;
         sclk_reg    <= 1'b0;
         mosi_reg    <= 1'b0;
         tx_reg      <= '0;
         rx_reg      <= '0;
         rx_data_reg <= '0;
      end else if (abort) begin
         active_reg <= 1'b0;
      end else if (start) begin
         active_reg <= 1'b1;
         cpha_reg   <= cpha;
         div_reg    <= div;
         cnt_reg    <= '0;
         half_reg   <= '0;
         sclk_reg   <= cpol;
         rx_reg     <= '0;
         if (!cpha) begin
            mosi_reg <= tx_data[DW-1];
            tx_reg   <= tx_data << 1;
         end else begin
            tx_reg   <= tx_data;
         end
      end else if (active_reg) begin
         if (half_end) begin
            cnt_reg  <= '0;
            half_reg <= half_reg + HW'(1);
            sclk_reg <= ~sclk_reg;
            if (sample_edge) rx_reg <= rx_shift;
            if (shift_edge) begin
               mosi_reg <= tx_reg[DW-1];
               tx_reg   <= tx_reg << 1;
            end
            if (last_edge) begin
               active_reg  <= 1'b0;
               rx_data_reg <= sample_edge ? rx_shift : rx_reg;
            end
         end else begin
            cnt_reg <= cnt_reg + DIVW'(1);
         end
      end
   end

   assign busy    = active_reg;
   assign finish  = last_edge && !abort;
   assign sclk    = active_reg ? sclk_reg : cpol;
   assign mosi    = mosi_reg;
   assign rx_data = rx_data_reg;

endmodule

// File: rtl/apb_spi_psramc.sv
// APB register block and sequencing FSM for the SPI PSRAM controller:
// power-up delay, chip-select control, tCEM guard and interrupt.
module apb_spi_psramc
   import psramc_pkg::*;
#(
   parameter int DW   = 8,
   parameter int NCS  = 1,
   parameter int DIVW = 8
) (
   input  logic           PCLK,
   input  logic           RESETN,
   input  logic           PSEL,
   input  logic           PENABLE,
   input  logic           PWRITE,
   input  logic [7:0]     PADDR,
   input  logic [31:0]    PWDATA,
   output logic [31:0]    PRDATA,
   output logic           PREADY,
   output logic           PSLVERR,
   output logic           SCLK,
   output logic           MOSI,
   input  logic           MISO,
   output logic [NCS-1:0] CSN,
   output logic           IRQ
);

   state_t state_reg, state_next;

   logic            en_reg, hold_reg, cpol_reg, cpha_reg;
   logic [1:0]      cssel_reg, cs_sel_reg;
   logic [31:0]     cyc_pu_reg, cyc_cem_reg, pu_cnt_reg, cem_cnt_reg;
   logic [DIVW-1:0] clkdiv_reg;
   logic            pu_done_reg, cem_err_reg, done_reg, cem_force_reg;

   logic [2:0]    idx;
   logic          addr_bad, access, wr, ctrl_wr, st_wr, tx_wr, tx_ok;
   logic          en_eff, hold_eff, abort, cs_low, cem_hit, cs_active;
   logic          busy, finish;
   logic [DW-1:0] rx_data;

   assign idx      = PADDR[4:2];
   assign addr_bad = (PADDR >= ADDR_LIMIT);
   assign access   = PSEL && PENABLE;
   assign wr       = access && PWRITE && !addr_bad;
   assign ctrl_wr  = wr && (idx == REG_CTRL);
   assign st_wr    = wr && (idx == REG_STATUS);
   assign tx_wr    = wr && (idx == REG_TXDATA);
   assign tx_ok    = tx_wr && pu_done_reg && !busy;
   // EN and HOLD act in the cycle they are written, not one cycle later
   assign en_eff   = ctrl_wr ? PWDATA[CTRL_EN] : en_reg;
   assign hold_eff = ctrl_wr ? PWDATA[CTRL_HOLD] : hold_reg;
   assign abort    = !en_eff;
   assign cs_low   = !(&CSN);
   // Fires on the edge that completes the CYC_CEM-th CS-low cycle
   assign cem_hit  = (cyc_cem_reg != 32'd0) && cs_low && (cem_cnt_reg + 32'd1 == cyc_cem_reg);

   // FSM state register
   always_ff @(posedge PCLK) begin
      if (!RESETN) state_reg <= S_OFF;
      else         state_reg <= state_next;
   end

   // FSM next-state logic; clearing EN overrides everything
   always_comb begin
      state_next = state_reg;
      if (abort) begin
         state_next = S_OFF;
      end else begin
         case (state_reg)
            S_OFF:   state_next = S_PWRUP;
            S_PWRUP: if (pu_cnt_reg == 32'd0) state_next = S_IDLE;
            S_IDLE:  if (tx_ok) state_next = S_SHIFT;
            S_SHIFT: if (finish)
                        state_next = (hold_eff && !cem_force_reg && !cem_hit) ? S_HOLD : S_IDLE;
            S_HOLD:  if (tx_ok) state_next = S_SHIFT;
                     else if (!hold_eff || cem_hit) state_next = S_IDLE;
            default: state_next = S_OFF;
         endcase
      end
   end

   // FSM outputs: chip select is low only while shifting or holding
   always_comb begin
      cs_active = (state_reg == S_SHIFT) || (state_reg == S_HOLD);
   end

   for (genvar gi = 0; gi < NCS; gi++) begin : g_csn
      assign CSN[gi] = !(cs_active && (cs_sel_reg == 2'(gi)));
   end

   // Configuration registers written over APB
   always_ff @(posedge PCLK) begin
      if (!RESETN) begin
         en_reg      <= 1'b0;
         hold_reg    <= 1'b0;
         cpol_reg    <= 1'b0;
         cpha_reg    <= 1'b0;
         cssel_reg   <= 2'd0;
         cyc_pu_reg  <= 32'd0;
         cyc_cem_reg <= 32'd0;
         clkdiv_reg  <= '0;
         cs_sel_reg  <= 2'd0;
      end else begin
         if (ctrl_wr) begin
            en_reg    <= PWDATA[CTRL_EN];
            hold_reg  <= PWDATA[CTRL_HOLD];
            cpol_reg  <= PWDATA[CTRL_CPOL];
            cpha_reg  <= PWDATA[CTRL_CPHA];
            cssel_reg <= PWDATA[1:0];
         end
         if (wr && idx == REG_CYC_PU)  cyc_pu_reg  <= PWDATA;
         if (wr && idx == REG_CYC_CEM) cyc_cem_reg <= PWDATA;
         if (wr && idx == REG_CLKDIV)  clkdiv_reg  <= PWDATA[DIVW-1:0];
         if (tx_ok)                    cs_sel_reg  <= cssel_reg;
      end
   end

   // Power-up and tCEM timers plus sticky status; a set event beats W1C
   always_ff @(posedge PCLK) begin
      if (!RESETN) begin
         pu_cnt_reg    <= 32'd0;
         cem_cnt_reg   <= 32'd0;
         pu_done_reg   <= 1'b0;
         cem_err_reg   <= 1'b0;
         done_reg      <= 1'b0;
         cem_force_reg <= 1'b0;
      end else begin
         if (state_reg == S_OFF)
            pu_cnt_reg <= cyc_pu_reg;
         else if (state_reg == S_PWRUP && pu_cnt_reg != 32'd0)
            pu_cnt_reg <= pu_cnt_reg - 32'd1;

         if (abort)
            pu_done_reg <= 1'b0;
         else if (state_reg == S_PWRUP && pu_cnt_reg == 32'd0)
            pu_done_reg <= 1'b1;

         cem_cnt_reg <= cs_low ? cem_cnt_reg + 32'd1 : 32'd0;

         if (finish)                       done_reg <= 1'b1;
         else if (st_wr && PWDATA[ST_DONE]) done_reg <= 1'b0;

         if (cem_hit)                          cem_err_reg <= 1'b1;
         else if (st_wr && PWDATA[ST_CEM_ERR]) cem_err_reg <= 1'b0;

         // A guard hit during a transfer forces release once it completes
         cem_force_reg <= (state_next == S_SHIFT) ? (cem_force_reg || cem_hit) : 1'b0;
      end
   end

   // Read mux, combinational from PADDR
   always_comb begin
      PRDATA = 32'd0;
      if (!addr_bad) begin
         case (idx)
            REG_CTRL: begin
               PRDATA[CTRL_EN]   = en_reg;
               PRDATA[CTRL_CPHA] = cpha_reg;
               PRDATA[CTRL_CPOL] = cpol_reg;
               PRDATA[CTRL_HOLD] = hold_reg;
               PRDATA[1:0]       = cssel_reg;
            end
            REG_CYC_PU:  PRDATA = cyc_pu_reg;
            REG_CYC_CEM: PRDATA = cyc_cem_reg;
            REG_CLKDIV:  PRDATA = 32'(clkdiv_reg);
            REG_RXDATA:  PRDATA = 32'(rx_data);
            REG_STATUS: begin
               PRDATA[ST_BUSY]    = busy;
               PRDATA[ST_PU_DONE] = pu_done_reg;
               PRDATA[ST_CEM_ERR] = cem_err_reg;
               PRDATA[ST_DONE]    = done_reg;
            end
            default: PRDATA = 32'd0;
         endcase
      end
   end

   assign PREADY  = 1'b1;
   assign PSLVERR = access && (addr_bad ||
                    (PWRITE && idx == REG_TXDATA && !(pu_done_reg && !busy)));
   assign IRQ     = done_reg || cem_err_reg;

   spi_shift_engine #(
      .DW   (DW),
      .DIVW (DIVW)
   ) u_engine (
      .PCLK    (PCLK),
      .RESETN  (RESETN),
      .start   (tx_ok),
      .abort   (abort),
      .tx_data (PWDATA[DW-1:0]),
      .cpol    (cpol_reg),
      .cpha    (cpha_reg),
      .div     (clkdiv_reg),
      .miso    (MISO),
      .busy    (busy),
      .finish  (finish),
      .sclk    (SCLK),
      .mosi    (MOSI),
      .rx_data (rx_data)
   );

endmodule

// File: tb/tb_apb_spi_psramc.sv
// Directed bench for apb_spi_psramc (DW=8, NCS=1, DIVW=8).
// PADDR rests on STATUS between accesses so PRDATA shows status every cycle.
module tb_apb_spi_psramc;

   localparam int DW = 8, NCS = 1, DIVW = 8;

   logic           PCLK = 1'b0, RESETN = 1'b0;
   logic           PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
   logic [7:0]     PADDR = 8'h18;
   logic [31:0]    PWDATA = 32'd0;
   logic [31:0]    PRDATA;
   logic           PREADY, PSLVERR, SCLK, MOSI, MISO, IRQ;
   logic [NCS-1:0] CSN;
   logic           loop = 1'b0, miso_tie = 1'b0;

   int checks = 0, errors = 0;

   logic        err;
   logic [31:0] rd;
   int          p0, n;

   assign MISO = loop ? MOSI : miso_tie;

   always #5 PCLK = ~PCLK;

   apb_spi_psramc #(.DW(DW), .NCS(NCS), .DIVW(DIVW)) dut (
      .PCLK(PCLK), .RESETN(RESETN), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .SCLK(SCLK), .MOSI(MOSI),
      .MISO(MISO), .CSN(CSN), .IRQ(IRQ)
   );

   // Capture MOSI on every SCLK rising edge
   logic       sclk_prev = 1'b0;
   logic [7:0] mon_bits = 8'd0;
   int         mon_pulses = 0;
   always @(negedge PCLK) begin
      sclk_prev <= SCLK;
      if (SCLK && !sclk_prev) begin
         mon_bits   <= {mon_bits[6:0], MOSI};
         mon_pulses <= mon_pulses + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic e);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(negedge PCLK);
      e = PSLVERR;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h18;
      $display("apb wr %02h <= %08h err=%0b", a, d, e);
   endtask

   task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic e);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(negedge PCLK);
      d = PRDATA; e = PSLVERR;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PADDR = 8'h18;
      $display("apb rd %02h -> %08h err=%0b", a, d, e);
   endtask

   task automatic wait_neg(input int k);
      repeat (k) @(negedge PCLK);
   endtask

   // Bounded wait for BUSY to drop; an expired budget is a failed check
   task automatic wait_idle(input int budget);
      int i = 0;
      @(negedge PCLK);
      while (PRDATA[0] && i < budget) begin
         @(negedge PCLK);
         i++;
      end
      chk("wait_idle", 32'(PRDATA[0]), 32'd0);
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge PCLK);
      @(negedge PCLK);
      chk("rst_csn", 32'(CSN), 32'd1);
      chk("rst_sclk", 32'(SCLK), 32'd0);
      chk("rst_mosi", 32'(MOSI), 32'd0);
      chk("rst_irq", 32'(IRQ), 32'd0);
      chk("rst_pslverr", 32'(PSLVERR), 32'd0);
      chk("rst_status", PRDATA, 32'd0);
      @(posedge PCLK); #1 RESETN = 1'b1;

      // TXDATA before power-up is refused
      apb_write(8'h10, 32'h55, err);
      chk("pre_pu_err", 32'(err), 32'd1);
      @(negedge PCLK);
      chk("pre_pu_csn", 32'(CSN), 32'd1);
      chk("pre_pu_status", PRDATA, 32'd0);

      // Power-up: PU_DONE rises on the 11th edge after the CTRL write
      apb_write(8'h04, 32'd10, err);
      apb_write(8'h0C, 32'd1, err);
      apb_write(8'h00, 32'h8000_0000, err);
      @(negedge PCLK);
      wait_neg(10);
      chk("pu_t11", 32'(PRDATA[1]), 32'd0);
      wait_neg(1);
      chk("pu_t12", 32'(PRDATA[1]), 32'd1);

      // Mode 0, loopback, 0xA5
      loop = 1'b1;
      p0 = mon_pulses;
      apb_write(8'h10, 32'hA5, err);
      chk("m0_err", 32'(err), 32'd0);
      @(negedge PCLK);
      chk("m0_busy_t1", 32'(PRDATA[0]), 32'd1);
      chk("m0_csn_t1", 32'(CSN), 32'd0);
      chk("m0_mosi_t1", 32'(MOSI), 32'd1);
      chk("m0_sclk_t1", 32'(SCLK), 32'd0);
      wait_neg(31);
      chk("m0_busy_t32", 32'(PRDATA[0]), 32'd1);
      wait_neg(1);
      chk("m0_busy_t33", 32'(PRDATA[0]), 32'd0);
      chk("m0_done", 32'(PRDATA[3]), 32'd1);
      chk("m0_irq", 32'(IRQ), 32'd1);
      chk("m0_csn_rel", 32'(CSN), 32'd1);
      chk("m0_pulses", 32'(mon_pulses - p0), 32'd8);
      chk("m0_mosi_bits", 32'(mon_bits), 32'hA5);
      apb_read(8'h14, rd, err);
      chk("m0_rx", rd, 32'hA5);
      apb_write(8'h18, 32'h8, err);
      @(negedge PCLK);
      chk("m0_done_clr", 32'(PRDATA[3]), 32'd0);
      chk("m0_irq_clr", 32'(IRQ), 32'd0);

      // Busy: second TXDATA refused, in-flight data intact; out-of-map read
      apb_write(8'h10, 32'h5A, err);
      apb_write(8'h10, 32'h00, err);
      chk("busy_tx_err", 32'(err), 32'd1);
      wait_idle(100);
      apb_read(8'h14, rd, err);
      chk("busy_rx", rd, 32'h5A);
      apb_read(8'h1C, rd, err);
      chk("rd_1c_err", 32'(err), 32'd1);
      apb_write(8'h18, 32'h8, err);

      // Mode 3, MISO tied high
      loop = 1'b0; miso_tie = 1'b1;
      apb_write(8'h00, 32'h8000_0600, err);
      @(negedge PCLK);
      chk("m3_sclk_idle", 32'(SCLK), 32'd1);
      apb_write(8'h10, 32'h3C, err);
      @(negedge PCLK);
      chk("m3_busy_t1", 32'(PRDATA[0]), 32'd1);
      chk("m3_sclk_t1", 32'(SCLK), 32'd1);
      wait_idle(100);
      chk("m3_sclk_end", 32'(SCLK), 32'd1);
      chk("m3_irq", 32'(IRQ), 32'd1);
      apb_read(8'h14, rd, err);
      chk("m3_rx", rd, 32'hFF);
      apb_write(8'h18, 32'h8, err);
      @(negedge PCLK);
      chk("m3_done_clr", 32'(PRDATA[3]), 32'd0);
      chk("m3_irq_clr", 32'(IRQ), 32'd0);

      // CSSEL beyond NCS: transfer runs with no chip select
      loop = 1'b1;
      apb_write(8'h00, 32'h8000_0001, err);
      apb_write(8'h10, 32'h3C, err);
      @(negedge PCLK);
      chk("oob_busy", 32'(PRDATA[0]), 32'd1);
      chk("oob_csn", 32'(CSN), 32'd1);
      wait_idle(100);
      apb_read(8'h14, rd, err);
      chk("oob_rx", rd, 32'h3C);
      apb_write(8'h18, 32'h8, err);

      // HOLD keeps CSN low until CTRL.HOLD is cleared
      apb_write(8'h00, 32'h8000_0100, err);
      apb_write(8'h10, 32'hC3, err);
      wait_idle(100);
      @(negedge PCLK);
      chk("hold_csn", 32'(CSN), 32'd0);
      apb_write(8'h00, 32'h8000_0000, err);
      @(negedge PCLK);
      chk("hold_rel_csn", 32'(CSN), 32'd1);
      apb_write(8'h18, 32'h8, err);

      // tCEM guard: CSN low for exactly 50 cycles in HOLD
      apb_write(8'h08, 32'd50, err);
      apb_write(8'h00, 32'h8000_0100, err);
      apb_write(8'h10, 32'h0F, err);
      @(negedge PCLK);
      wait_neg(49);
      chk("cem_t50_csn", 32'(CSN), 32'd0);
      chk("cem_t50_err", 32'(PRDATA[2]), 32'd0);
      wait_neg(1);
      chk("cem_t51_csn", 32'(CSN), 32'd1);
      chk("cem_t51_err", 32'(PRDATA[2]), 32'd1);
      chk("cem_irq", 32'(IRQ), 32'd1);
      apb_write(8'h18, 32'h4, err);
      @(negedge PCLK);
      chk("cem_clr", 32'(PRDATA[2]), 32'd0);
      apb_write(8'h18, 32'h8, err);
      @(negedge PCLK);
      chk("cem_irq_clr", 32'(IRQ), 32'd0);
      apb_write(8'h08, 32'd0, err);
      apb_write(8'h00, 32'h8000_0000, err);

      // Abort by clearing EN mid-transfer
      apb_write(8'h10, 32'h96, err);
      wait_neg(10);
      apb_write(8'h00, 32'h0, err);
      @(negedge PCLK);
      chk("ab_csn", 32'(CSN), 32'd1);
      chk("ab_status", PRDATA, 32'd0);
      chk("ab_sclk", 32'(SCLK), 32'd0);
      apb_read(8'h14, rd, err);
      chk("ab_rx", rd, 32'h0F);

      // Reset mid-transfer
      apb_write(8'h00, 32'h8000_0000, err);
      n = 0;
      @(negedge PCLK);
      while (!PRDATA[1] && n < 30) begin
         @(negedge PCLK);
         n++;
      end
      chk("rst2_pu", 32'(PRDATA[1]), 32'd1);
      apb_write(8'h10, 32'h77, err);
      wait_neg(6);
      @(posedge PCLK); #1 RESETN = 1'b0;
      @(posedge PCLK);
      @(negedge PCLK);
      chk("rst2_csn", 32'(CSN), 32'd1);
      chk("rst2_status", PRDATA, 32'd0);
      chk("rst2_sclk", 32'(SCLK), 32'd0);
      chk("rst2_irq", 32'(IRQ), 32'd0);
      @(posedge PCLK); #1 RESETN = 1'b1;
      apb_read(8'h00, rd, err);
      chk("rst2_ctrl", rd, 32'd0);
      apb_read(8'h04, rd, err);
      chk("rst2_cyc_pu", rd, 32'd0);
      apb_read(8'h0C, rd, err);
      chk("rst2_clkdiv", rd, 32'd0);
      apb_read(8'h14, rd, err);
      chk("rst2_rx", rd, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_spi_psramc.md
Name: apb_spi_psramc

Overview:
- Parametrised APB slave for the PSRAM controller. Holds the control and timing registers and drives a full SPI master engine with configurable transfer width, clock divider, CPOL/CPHA and multiple chip selects.
- Enforces the PSRAM power-up delay (tPU) in hardware before any transfer is allowed.
- Guards the maximum CS-low time (tCEM).
- Sits on the peripheral APB bus next to the other APB register blocks and drives the PSRAM pins directly.

Parameters:
- DW, 8, SPI transfer width in bits, legal 8..32.
- NCS, 1, number of chip-select outputs, legal 1..4.
- DIVW, 8, width of the SCLK divider register.

Ports:
- PCLK  in  1  system and APB clock
- RESETN  in  1  synchronous active-low reset
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  APB write
- PADDR  in  8  APB byte address; word index is PADDR[4:2]
- PWDATA  in  32  APB write data
- PRDATA  out  32  APB read data, combinational from PADDR
- PREADY  out  1  always 1, zero wait states
- PSLVERR  out  1  error response, valid when PSEL&PENABLE
- SCLK  out  1  SPI clock
- MOSI  out  1  SPI data out, MSB first
- MISO  in  1  SPI data in
- CSN  out  NCS  chip selects, active low
- IRQ  out  1  level interrupt, equal to DONE | CEM_ERR

Behaviour:
- Reset: the design is reset with RESETN, synchronous, active-low, on clock PCLK. Reset values:
  - all registers 0
  - CSN all 1, SCLK 0, MOSI 0, PSLVERR 0, IRQ 0
  - FSM in OFF
- Register map (word offsets):
  - 0x00 CTRL: [31] EN, [1:0] CSSEL, [8] HOLD, [9] CPOL, [10] CPHA.
  - 0x04 CYC_PU: tPU cycle count.
  - 0x08 CYC_CEM: tCEM cycle count; 0 disables the guard.
  - 0x0C CLKDIV: [DIVW-1:0]; SCLK half-period = CLKDIV+1 PCLK cycles.
  - 0x10 TXDATA: write-only. Writing starts a transfer. Reads return 0.
  - 0x14 RXDATA: read-only, [DW-1:0], zero-extended.
  - 0x18 STATUS: [0] BUSY, [1] PU_DONE, [2] CEM_ERR (sticky, write-1-to-clear), [3] DONE (sticky, write-1-to-clear).
- Register writes are committed on PSEL&PENABLE&PWRITE.
- PSLVERR=1 on:
  - any access to offsets 0x1C and above;
  - a TXDATA write while BUSY=1 or PU_DONE=0. Such a write is discarded and has no effect.
- CTRL writes while BUSY=1 update EN immediately. CPOL, CPHA, CSSEL and CLKDIV are sampled only at transfer start.
- FSM states: OFF, PWRUP, IDLE, SHIFT, HOLD.
  - OFF: if EN=1, load counter with CYC_PU and go to PWRUP.
  - PWRUP: counter decrements each cycle. At 0, set PU_DONE and go to IDLE. CYC_PU=0 means PWRUP lasts 1 cycle.
  - IDLE or HOLD: a valid TXDATA write in cycle T:
    - loads the shift register and sets BUSY in T+1;
    - drives CSN[CSSEL]=0 in T+1;
    - MOSI=MSB in T+1 if CPHA=0;
    - goes to SHIFT.
  - SHIFT: 2*DW half-periods.
    - CPHA=0: sample MISO on the leading edge, shift MOSI on the trailing edge.
    - CPHA=1: shift on the leading edge, sample on the trailing edge.
    - SCLK idles at CPOL.
    - On the final half-period end: RXDATA updated, BUSY=0, DONE=1 in the same cycle. Go to HOLD if HOLD=1, else go to IDLE with CSN high the next cycle.
  - HOLD: CSN stays low. Clearing CTRL.HOLD releases CSN next cycle and returns to IDLE.
- Transfer time: total from the TXDATA write to BUSY=0 = 1 + 2*DW*(CLKDIV+1) cycles.
- tCEM guard:
  - The counter runs whenever any CSN is low and clears when all CSN are high.
  - When it reaches CYC_CEM (CYC_CEM≠0): set CEM_ERR.
  - In HOLD, force CSN high the next cycle and go to IDLE.
  - In SHIFT, complete the transfer, then force release regardless of HOLD.
- EN cleared in any state: abort within 1 cycle. CSN all 1, SCLK=CPOL, BUSY=0, PU_DONE=0, FSM to OFF. RXDATA is not updated.
- W1C write coinciding with a set event in the same cycle: the set wins.
- CSSEL ≥ NCS: no CSN is asserted; the transfer still runs.

Decomposition:
- Shared package psramc_pkg holds:
  - register offset constants;
  - CTRL and STATUS bit-index constants;
  - the FSM state enum.
- One sub-module, spi_shift_engine (parametrised DW, DIVW). It contains the divider, the edge generator and the shift/sample register, with start/done handshake.
- The APB decode, registers, PU and tCEM timers, and FSM stay in the top level.

Test Plan:
- Power-up: EN=1, CYC_PU=10 -> PU_DONE=1 exactly 11 cycles after the CTRL write. A TXDATA write before that gets PSLVERR=1 and no CSN activity.
- Mode 0 transfer: DW=8, CLKDIV=1, TXDATA=0xA5, MISO loopback from MOSI -> 8 SCLK pulses, MOSI bit sequence 1,0,1,0,0,1,0,1. RXDATA=0xA5, BUSY low after 1+32 cycles, DONE=1, IRQ=1.
- Mode 3: CPOL=1, CPHA=1, TXDATA=0x3C, MISO tied 1 -> SCLK idles high, RXDATA=0xFF. Write 0x8 to STATUS clears DONE and IRQ.
- Busy/illegal access: a TXDATA write during SHIFT gets PSLVERR=1 and the in-flight data is unchanged. A read at 0x1C gets PSLVERR=1.
- tCEM: HOLD=1, CYC_CEM=50, one transfer -> CSN forced high when CS-low count reaches 50, CEM_ERR=1. Write 0x4 to STATUS clears it.
- Abort: EN cleared mid-SHIFT -> next cycle CSN=all 1, BUSY=0, PU_DONE=0, RXDATA unchanged. RESETN low mid-transfer gives the same outputs, with all registers returned to 0.
